// File: rtl/instr_feeder.sv
// Program store and instruction streamer for the tiny core.
// It streams one word per clock and redirects on cjump with no bubble.
//
// state | meaning
// IDLE  | program may be loaded, waiting for start
// RUN   | streaming words, more remain after the one on instr
// TAIL  | the last program word is on instr
// HALT  | program finished or faulted, loads and start accepted
module instr_feeder #(
    parameter int IW    = 6,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          start,
    input  logic          cjump,
    input  logic [AW-1:0] jump_target,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          fault
);

    typedef enum logic [1:0] {IDLE, RUN, TAIL, HALT} state_t;

    state_t        state, state_n;
    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] prog_last, prog_last_n, pc_n;
    logic [IW-1:0] instr_n;
    logic          instr_valid_n, halted_n, fault_n;
    logic          mem_we, jump;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            prog_last   <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            instr_valid <= instr_valid_n;
            halted      <= halted_n;
            fault       <= fault_n;
            prog_last   <= prog_last_n;
        end
    end

    // Program memory is deliberately outside reset so it survives rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instr_n       = instr;
        instr_valid_n = instr_valid;
        halted_n      = halted;
        fault_n       = fault;
        prog_last_n   = prog_last;
        mem_we        = 1'b0;
        jump          = cjump && instr_valid;

        case (state)
            IDLE, HALT: begin
                if (load_valid) begin
                    mem_we      = !rst;
                    prog_last_n = (load_addr > prog_last) ? load_addr : prog_last;
                    state_n     = IDLE;
                    halted_n    = 1'b0;
                    fault_n     = 1'b0;
                end else if (start) begin
                    instr_n       = mem[0];
                    instr_valid_n = 1'b1;
                    pc_n          = AW'(1);
                    halted_n      = 1'b0;
                    fault_n       = 1'b0;
                    state_n       = (prog_last == '0) ? TAIL : RUN;
                end
            end
            RUN, TAIL: begin
                if (jump) begin
                    if (jump_target <= prog_last) begin
                        instr_n = mem[jump_target];
                        pc_n    = jump_target + AW'(1);
                        state_n = (jump_target == prog_last) ? TAIL : RUN;
                    end else begin
                        instr_valid_n = 1'b0;
                        instr_n       = '0;
                        fault_n       = 1'b1;
                        halted_n      = 1'b1;
                        state_n       = HALT;
                    end
                end else if (state == RUN) begin
                    instr_n = mem[pc];
                    pc_n    = pc + AW'(1);
                    state_n = (pc == prog_last) ? TAIL : RUN;
                end else begin
                    instr_valid_n = 1'b0;
                    instr_n       = '0;
                    halted_n      = 1'b1;
                    state_n       = HALT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_feeder.sv
// Scoreboard bench for instr_feeder: drivers queue expected words, a negedge
// monitor pops and compares each valid instruction.
module tb_instr_feeder;

    logic       clk = 1'b0;
    logic       rst, load_valid, start, cjump;
    logic [3:0] load_addr, jump_target;
    logic [5:0] load_data, instr;
    logic       instr_valid, halted, fault;
    logic [3:0] pc;

    int checks = 0;
    int failures = 0;
    logic [5:0] exp_q[$];

    instr_feeder #(.IW(6), .AW(4), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_addr(load_addr),
        .load_data(load_data), .start(start), .cjump(cjump),
        .jump_target(jump_target), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (instr_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_instr actual=0x%0h expected=none", instr);
            end else begin
                chk("instr_stream", int'(instr), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [5:0] d);
        load_valid = 1'b1; load_addr = a; load_data = d;
        cyc(1);
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic push(input logic [5:0] w);
        exp_q.push_back(w);
    endtask

    task automatic drained(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            cyc(1);
            guard++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; start = 1'b0; cjump = 1'b0;
        load_addr = '0; load_data = '0; jump_target = '0;
        cyc(2);
        rst = 1'b0;
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);

        // Straight-line program 01..04
        for (int i = 0; i < 4; i++) load(4'(i), 6'(i + 1));
        push(6'h01); push(6'h02); push(6'h03); push(6'h04);
        pulse_start();
        cyc(4);
        chk("t1_valid", instr_valid, 0);
        chk("t1_halted", halted, 1);
        chk("t1_pc", pc, 4);
        drained("t1_drain");

        // Back jump to 1 while 03 is on instr
        push(6'h01); push(6'h02); push(6'h03);
        push(6'h02); push(6'h03); push(6'h04);
        pulse_start();
        cyc(2);
        cjump = 1'b1; jump_target = 4'd1;
        cyc(1);
        cjump = 1'b0;
        chk("t2_pc_after_jump", pc, 2);
        cyc(3);
        chk("t2_halted", halted, 1);
        chk("t2_pc", pc, 4);
        drained("t2_drain");

        // Jump to 0 from TAIL restarts the stream
        push(6'h01); push(6'h02); push(6'h03); push(6'h04);
        push(6'h01); push(6'h02); push(6'h03); push(6'h04);
        pulse_start();
        cyc(3);
        cjump = 1'b1; jump_target = 4'd0;
        cyc(1);
        cjump = 1'b0;
        chk("t3_pc_after_jump", pc, 1);
        chk("t3_not_halted", halted, 0);
        cyc(4);
        chk("t3_halted", halted, 1);
        drained("t3_drain");

        // Out-of-range jump faults
        push(6'h01); push(6'h02);
        pulse_start();
        cyc(1);
        cjump = 1'b1; jump_target = 4'd9;
        cyc(1);
        cjump = 1'b0;
        chk("t4_fault", fault, 1);
        chk("t4_halted", halted, 1);
        chk("t4_valid", instr_valid, 0);
        drained("t4_drain");
        push(6'h01); push(6'h02); push(6'h03); push(6'h04);
        pulse_start();
        chk("t4_fault_cleared", fault, 0);
        chk("t4_halt_cleared", halted, 0);
        cyc(4);
        chk("t4_rerun_halted", halted, 1);
        chk("t4_rerun_fault", fault, 0);
        drained("t4_rerun_drain");

        // Load in HALT returns to IDLE; load beats a simultaneous start
        load(4'd4, 6'h05);
        chk("t5_halt_cleared_by_load", halted, 0);
        start = 1'b1;
        load(4'd5, 6'h3F);
        start = 1'b0;
        cyc(1);
        chk("t5_no_run", instr_valid, 0);
        for (int i = 1; i <= 5; i++) push(6'(i));
        push(6'h3F);
        pulse_start();
        cyc(6);
        chk("t5_halted", halted, 1);
        chk("t5_pc", pc, 6);
        drained("t5_drain");

        // Reset mid-run; prog_last resets so only word 0 streams
        push(6'h01); push(6'h02);
        pulse_start();
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t6_valid", instr_valid, 0);
        chk("t6_pc", pc, 0);
        chk("t6_halted", halted, 0);
        drained("t6_drain");
        push(6'h01);
        pulse_start();
        cyc(1);
        chk("t6_single_halted", halted, 1);
        chk("t6_single_pc", pc, 1);
        drained("t6_single_drain");

        // Memory survived reset: rewrite only the last word
        load(4'd3, 6'h04);
        push(6'h01); push(6'h02); push(6'h03); push(6'h04);
        pulse_start();
        cyc(4);
        chk("t6_replay_halted", halted, 1);
        chk("t6_replay_pc", pc, 4);
        drained("t6_replay_drain");

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
